sitcpxg_tx_stream_arbiter: RTL and testbench
============================================

Name: sitcpxg_tx_stream_arbiter

Overview:
- Shares the single 10GbE SiTCP TCP transmit port (USER_TX_D/USER_TX_B/USER_TX_AFULL) between NCH user data streams.
- Grants bursts round-robin and optionally prepends a per-burst header word so the host can demultiplex the streams.
- Honours the TX almost-full back-pressure.
- Sequences the session close handshake so close is acknowledged only at a burst boundary.

Parameters:
NCH, 4, number of requesting streams (2..8)
MAX_BURST, 64, maximum data words per grant before forced re-arbitration (1..255)
HDR_EN, 1, 1 = emit an 8-byte header word ahead of each burst

Ports:
XGMII_CLOCK  in  1  sole clock
RSTs  in  1  asynchronous active-high reset
CH_TX_D  in  NCH*64  stream data, stream i at [64i+63:64i], big endian
CH_TX_B  in  NCH*4  valid byte count per word, stream i at [4i+3:4i], 1..8
CH_VALID  in  NCH  word present on stream i
CH_LAST  in  NCH  word is last of the stream's packet
CH_READY  out  NCH  word on stream i accepted this cycle when VALID&READY
USER_TX_D  out  64  to SiTCP write data
USER_TX_B  out  4  to SiTCP byte count, 0 = no write
USER_TX_AFULL  in  1  from SiTCP, stop writing
USER_SESSION_ESTABLISHED  in  1  from SiTCP
USER_SESSION_CLOSE_REQ  in  1  from SiTCP
USER_SESSION_CLOSE_ACK  out  1  to SiTCP
GRANT_CH  out  3  current/last granted stream index
BUSY  out  1  burst in progress

Behaviour:
- Reset values: CH_READY=0, USER_TX_D=0, USER_TX_B=0, USER_SESSION_CLOSE_ACK=0, GRANT_CH=0, BUSY=0, RR pointer=0, all sequence counters=0, state IDLE.
- States: IDLE, HDR, DATA, CLOSE.
- IDLE:
  - If CLOSE_REQ=1, go to CLOSE.
  - Else if ESTABLISHED=1, AFULL=0 and any CH_VALID=1: grant the first valid stream at or after the RR pointer (wrap modulo NCH), latch it in GRANT_CH, set BUSY=1.
  - Go to HDR if HDR_EN=1, otherwise DATA.
- HDR (one cycle, only when AFULL=0; otherwise wait):
  - Emit USER_TX_D = {16'hA5C3, 8'h00, 5'b0, ch[2:0], seq[ch][31:0]}, USER_TX_B=8.
  - seq[ch] increments by 1 modulo 2^32 after emission.
- DATA:
  - CH_READY[g] = ESTABLISHED & ~AFULL; all other CH_READY bits = 0.
  - On accept: next cycle USER_TX_D = data, USER_TX_B = CH_TX_B. Latency is exactly 1 register stage.
  - Word counter increments per accept.
  - Burst ends on accept of CH_LAST=1 or when the counter reaches MAX_BURST, whichever comes first.
  - At burst end: RR pointer = g+1 mod NCH, BUSY=0, go to IDLE. Re-grant is possible on the next cycle, giving 1 idle cycle between bursts.
  - VALID=0 inside a burst: stall in DATA and keep the grant.
- Cycles with no accept and no header drive USER_TX_B=0; USER_TX_D holds its last value.
- AFULL: sampled combinationally into CH_READY, so no word is accepted in any cycle with AFULL=1. The 1-cycle output register is covered by SiTCP's AFULL margin.
- CLOSE_REQ while in DATA/HDR: the current burst completes first (data still flows while ESTABLISHED=1), then the block goes to CLOSE instead of re-arbitrating.
- CLOSE: USER_SESSION_CLOSE_ACK=1, registered, one cycle after entry. Held while CLOSE_REQ=1. Drops one cycle after CLOSE_REQ=0, then go to IDLE.
- ESTABLISHED falling in any state other than CLOSE:
  - Next cycle: CH_READY=0, burst abandoned, BUSY=0, state IDLE.
  - All seq counters and the RR pointer reset to 0.
  - A CLOSE_REQ pending at that time is still acknowledged.
- CH_TX_B values of 0 or >8 on an accepted word: word is consumed, USER_TX_B=0 (dropped).
- Asynchronous reset mid-burst: all outputs go to their reset values immediately; no partial word is emitted afterwards.

Test Plan:
- NCH=4, HDR_EN=1, streams 0 and 2 each send 3-word packets with LAST on word 3 -> output HDR(ch0,seq0), 3 words, idle cycle, HDR(ch2,seq0), 3 words; GRANT_CH 0 then 2; total 8 writes with USER_TX_B=8.
- MAX_BURST=4, stream 1 holds VALID for 10 words and stream 3 is valid -> ch1 carries 4 words, then ch3 is granted before ch1 resumes; ch1 header seq values 0,1,2.
- AFULL asserted for 5 cycles mid-burst -> CH_READY=0 and USER_TX_B=0 for exactly those cycles (+1 register stage); no word lost or duplicated; data order preserved.
- CLOSE_REQ rises at word 2 of an 8-word burst -> all 8 words emitted, CLOSE_ACK=1 one cycle after the last word, no new grant; CLOSE_REQ drop -> ACK=0 one cycle later.
- ESTABLISHED drops mid-burst -> CH_READY=0 next cycle; next session's first header shows seq=0 and grant starts from stream 0.
- RSTs pulsed asynchronously mid-burst -> all outputs 0 within the same cycle; BUSY=0, state IDLE.

Source files
------------

// File: rtl/sitcpxg_tx_stream_arbiter_if.sv
// Bus bundle between the NCH user streams, the arbiter and the SiTCP 10GbE
// TCP transmit port.
//   master : arbiter side (drives CH_READY, USER_TX_*, CLOSE_ACK, GRANT_CH, BUSY)
//   slave  : environment side (streams + SiTCP)
// Stream i occupies CH_TX_D[64i+63:64i] (big endian) and CH_TX_B[4i+3:4i].
interface sitcpxg_tx_stream_arbiter_if #(
  parameter int NCH = 4
);
  logic [NCH*64-1:0] CH_TX_D;
  logic [NCH*4-1:0]  CH_TX_B;
  logic [NCH-1:0]    CH_VALID;
  logic [NCH-1:0]    CH_LAST;
  logic [NCH-1:0]    CH_READY;
  logic [63:0]       USER_TX_D;
  logic [3:0]        USER_TX_B;
  logic              USER_TX_AFULL;
  logic              USER_SESSION_ESTABLISHED;
  logic              USER_SESSION_CLOSE_REQ;
  logic              USER_SESSION_CLOSE_ACK;
  logic [2:0]        GRANT_CH;
  logic              BUSY;

  modport master (
    input  CH_TX_D, CH_TX_B, CH_VALID, CH_LAST,
    input  USER_TX_AFULL, USER_SESSION_ESTABLISHED, USER_SESSION_CLOSE_REQ,
    output CH_READY, USER_TX_D, USER_TX_B, USER_SESSION_CLOSE_ACK,
    output GRANT_CH, BUSY
  );

  modport slave (
    output CH_TX_D, CH_TX_B, CH_VALID, CH_LAST,
    output USER_TX_AFULL, USER_SESSION_ESTABLISHED, USER_SESSION_CLOSE_REQ,
    input  CH_READY, USER_TX_D, USER_TX_B, USER_SESSION_CLOSE_ACK,
    input  GRANT_CH, BUSY
  );
endinterface

// File: rtl/sitcpxg_tx_stream_arbiter.sv
// Round-robin burst arbiter sharing the SiTCP 10GbE TCP TX port between NCH
// streams. Each grant optionally starts with an 8-byte header
// {A5C3, 00, ch, seq[ch]} so the host can demultiplex; a burst ends on LAST or
// after MAX_BURST accepted words. AFULL gates CH_READY combinationally, data
// reaches USER_TX_* through one register stage. Session close is acknowledged
// only at a burst boundary; loss of ESTABLISHED abandons the burst and clears
// the round-robin pointer and all header sequence counters.
// Ports:
//   XGMII_CLOCK : clock
//   RSTs        : asynchronous active-high reset
//   bus         : stream + SiTCP bundle (master modport)
module sitcpxg_tx_stream_arbiter #(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 64,
  parameter int HDR_EN    = 1
) (
  input  logic                            XGMII_CLOCK,
  input  logic                            RSTs,
  sitcpxg_tx_stream_arbiter_if.master     bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;

  logic [1:0]       state;
  logic [2:0]       grant;
  logic [2:0]       rr;
  logic             busy;
  logic             ack;
  logic [63:0]      tx_d;
  logic [3:0]       tx_b;
  logic [7:0]       cnt;
  logic [7:0][31:0] seq;

  logic est, afull, close_req;
  assign est       = bus.USER_SESSION_ESTABLISHED;
  assign afull     = bus.USER_TX_AFULL;
  assign close_req = bus.USER_SESSION_CLOSE_REQ;

  // Streams widened to 8 lanes so a 3-bit grant index is always in range;
  // absent lanes read as idle.
  logic [7:0][63:0] ch_d;
  logic [7:0][3:0]  ch_b;
  logic [7:0]       ch_v;
  logic [7:0]       ch_l;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    if (i < NCH) begin : g_on
      assign ch_d[i] = bus.CH_TX_D[i*64 +: 64];
      assign ch_b[i] = bus.CH_TX_B[i*4 +: 4];
      assign ch_v[i] = bus.CH_VALID[i];
      assign ch_l[i] = bus.CH_LAST[i];
      assign bus.CH_READY[i] = (state == S_DATA) && (grant == 3'(i)) && est && !afull;
    end else begin : g_off
      assign ch_d[i] = '0;
      assign ch_b[i] = '0;
      assign ch_v[i] = 1'b0;
      assign ch_l[i] = 1'b0;
    end
  end

  logic [63:0] sel_d;
  logic [3:0]  sel_b;
  logic        sel_last;
  logic        accept;
  assign sel_d    = ch_d[grant];
  assign sel_b    = ch_b[grant];
  assign sel_last = ch_l[grant];
  assign accept   = (state == S_DATA) && ch_v[grant] && est && !afull;

  // First valid stream at or after the round-robin pointer, wrapping at NCH.
  logic [2:0] pick;
  logic       found;
  logic [3:0] idx;
  always_comb begin
    pick  = rr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr} + 4'(k);
      if (idx >= 4'(NCH)) idx = idx - 4'(NCH);
      if (!found && ch_v[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
  end

  logic [2:0] rr_next;
  assign rr_next = (grant == 3'(NCH-1)) ? 3'd0 : grant + 3'd1;

  always_ff @(posedge XGMII_CLOCK or posedge RSTs) begin
    if (RSTs) begin
      state <= S_IDLE;
      grant <= '0;
      rr    <= '0;
      busy  <= 1'b0;
      ack   <= 1'b0;
      tx_d  <= '0;
      tx_b  <= '0;
      cnt   <= '0;
      seq   <= '0;
    end else begin
      tx_b <= 4'd0;  // no write unless a header or word goes out this cycle
      if (state == S_CLOSE) begin
        // ACK follows REQ one cycle late; leave as soon as REQ is seen low.
        ack <= close_req;
        if (!close_req) state <= S_IDLE;
      end else if (!est) begin
        // Session gone: abandon burst, restart numbering for the next session.
        busy  <= 1'b0;
        rr    <= '0;
        seq   <= '0;
        cnt   <= '0;
        state <= close_req ? S_CLOSE : S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (close_req) begin
              state <= S_CLOSE;
            end else if (!afull && found) begin
              grant <= pick;
              busy  <= 1'b1;
              cnt   <= '0;
              state <= (HDR_EN != 0) ? S_HDR : S_DATA;
            end
          end
          S_HDR: begin
            if (!afull) begin
              tx_d       <= {16'hA5C3, 8'h00, 5'b0, grant, seq[grant]};
              tx_b       <= 4'd8;
              seq[grant] <= seq[grant] + 32'd1;
              state      <= S_DATA;
            end
          end
          S_DATA: begin
            if (accept) begin
              tx_d <= sel_d;
              // Illegal byte counts are consumed but never written.
              tx_b <= (sel_b != 4'd0 && sel_b <= 4'd8) ? sel_b : 4'd0;
              if (sel_last || cnt == 8'(MAX_BURST-1)) begin
                busy  <= 1'b0;
                rr    <= rr_next;
                cnt   <= '0;
                // A pending close is taken here, skipping re-arbitration.
                state <= close_req ? S_CLOSE : S_IDLE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.USER_TX_D              = tx_d;
  assign bus.USER_TX_B              = tx_b;
  assign bus.USER_SESSION_CLOSE_ACK = ack;
  assign bus.GRANT_CH               = grant;
  assign bus.BUSY                   = busy;

endmodule

// File: tb/tb_sitcpxg_tx_stream_arbiter.sv
module tb_sitcpxg_tx_stream_arbiter;

  localparam int NCH = 4;

  logic clk;
  logic rst;

  sitcpxg_tx_stream_arbiter_if #(.NCH(NCH)) bus ();

  sitcpxg_tx_stream_arbiter #(.NCH(NCH), .MAX_BURST(4), .HDR_EN(1)) dut (
    .XGMII_CLOCK (clk),
    .RSTs        (rst),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        last;
    logic [3:0]  b;
    logic [63:0] d;
  } word_t;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  b;
    logic [2:0]  g;
  } exp_t;

  word_t srcq [NCH][$];
  exp_t  sb [$];
  int    acc [NCH];
  int    tests = 0;
  int    fails = 0;
  int    wid   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input int ch, input int s);
    exp_t e;
    e.d = 64'hA5C3_0000_0000_0000 | (64'(ch) << 32) | 64'(unsigned'(s));
    e.b = 4'd8;
    e.g = 3'(ch);
    sb.push_back(e);
  endtask

  task automatic word(input int ch, input logic [3:0] b, input logic last, input bit emit);
    word_t w;
    exp_t  e;
    w.d = {8'(ch), 8'hDA, 16'(wid), 32'($urandom)};
    w.b = b;
    w.last = last;
    wid++;
    srcq[ch].push_back(w);
    if (emit) begin
      e.d = w.d;
      e.b = b;
      e.g = 3'(ch);
      sb.push_back(e);
    end
  endtask

  task automatic pkt(input int ch, input int n);
    for (int i = 0; i < n; i++) word(ch, 4'd8, (i == n-1), 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (sb.size() != 0 || bus.BUSY); i++) step();
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    chk({tag, "_busy"}, 64'(bus.BUSY), 64'd0);
  endtask

  task automatic wait_left(input int n);
    for (int i = 0; i < 200 && sb.size() > n; i++) step();
  endtask

  // Stream sources: hold VALID while a word is queued, pop on handshake.
  initial begin
    logic [NCH-1:0] hs;
    bus.CH_TX_D  = '0;
    bus.CH_TX_B  = '0;
    bus.CH_VALID = '0;
    bus.CH_LAST  = '0;
    for (int c = 0; c < NCH; c++) acc[c] = 0;
    forever begin
      @(negedge clk);
      hs = bus.CH_VALID & bus.CH_READY;
      @(posedge clk);
      #2;
      for (int c = 0; c < NCH; c++) begin
        if (hs[c] && srcq[c].size() > 0) begin
          void'(srcq[c].pop_front());
          acc[c]++;
        end
        if (srcq[c].size() > 0) begin
          bus.CH_TX_D[c*64 +: 64] = srcq[c][0].d;
          bus.CH_TX_B[c*4 +: 4]   = srcq[c][0].b;
          bus.CH_LAST[c]          = srcq[c][0].last;
          bus.CH_VALID[c]         = 1'b1;
        end else begin
          bus.CH_VALID[c] = 1'b0;
          bus.CH_LAST[c]  = 1'b0;
        end
      end
    end
  end

  // Output monitor: every write must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.USER_TX_B !== 4'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'(bus.USER_TX_B), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("tx_d", bus.USER_TX_D, e.d);
          chk("tx_b", 64'(bus.USER_TX_B), 64'(e.b));
          chk("grant_ch", 64'(bus.GRANT_CH), 64'(e.g));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.USER_TX_AFULL            = 1'b0;
    bus.USER_SESSION_ESTABLISHED = 1'b0;
    bus.USER_SESSION_CLOSE_REQ   = 1'b0;
    step();
    step();
    chk("rst_tx_d", bus.USER_TX_D, 64'd0);
    chk("rst_tx_b", 64'(bus.USER_TX_B), 64'd0);
    chk("rst_ready", 64'(bus.CH_READY), 64'd0);
    chk("rst_ack", 64'(bus.USER_SESSION_CLOSE_ACK), 64'd0);
    chk("rst_grant", 64'(bus.GRANT_CH), 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    rst = 1'b0;
    step();
    bus.USER_SESSION_ESTABLISHED = 1'b1;

    // Two 3-word packets on streams 0 and 2.
    push_hdr(0, 0); pkt(0, 3);
    push_hdr(2, 0); pkt(2, 3);
    wait_drain("two_pkts");
    chk("rr_grant_after", 64'(bus.GRANT_CH), 64'd2);

    // MAX_BURST=4 forced re-arbitration; rr pointer is 3, so stream 3 leads.
    // Stream 1 word 5 carries B=9 (dropped), word 8 a short B=3.
    push_hdr(3, 0); for (int i = 0; i < 4; i++) word(3, 4'd8, 1'b0, 1'b1);
    push_hdr(1, 0); for (int i = 0; i < 4; i++) word(1, 4'd8, 1'b0, 1'b1);
    push_hdr(3, 1); for (int i = 0; i < 4; i++) word(3, 4'd8, (i == 3), 1'b1);
    push_hdr(1, 1);
    word(1, 4'd8, 1'b0, 1'b1);
    word(1, 4'd9, 1'b0, 1'b0);
    word(1, 4'd8, 1'b0, 1'b1);
    word(1, 4'd8, 1'b0, 1'b1);
    push_hdr(1, 2);
    word(1, 4'd3, 1'b0, 1'b1);
    word(1, 4'd8, 1'b1, 1'b1);
    wait_drain("max_burst");

    // AFULL for 5 cycles mid-burst.
    push_hdr(0, 1); pkt(0, 4);
    wait_left(3);
    bus.USER_TX_AFULL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("afull_ready", 64'(bus.CH_READY), 64'd0);
      if (k > 0) chk("afull_tx_b", 64'(bus.USER_TX_B), 64'd0);
      step();
    end
    bus.USER_TX_AFULL = 1'b0;
    chk("afull_tail_tx_b", 64'(bus.USER_TX_B), 64'd0);
    wait_drain("afull");

    // CLOSE_REQ during a burst: burst completes, then ACK.
    push_hdr(2, 1); pkt(2, 3);
    wait_left(2);
    bus.USER_SESSION_CLOSE_REQ = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      chk("close_ack_early", 64'(bus.USER_SESSION_CLOSE_ACK), 64'd0);
      step();
    end
    chk("close_ack", 64'(bus.USER_SESSION_CLOSE_ACK), 64'd1);
    chk("close_busy", 64'(bus.BUSY), 64'd0);
    push_hdr(3, 2); word(3, 4'd8, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("close_no_grant", 64'(bus.BUSY), 64'd0);
      chk("close_ack_hold", 64'(bus.USER_SESSION_CLOSE_ACK), 64'd1);
    end
    bus.USER_SESSION_CLOSE_REQ = 1'b0;
    step();
    chk("close_ack_drop", 64'(bus.USER_SESSION_CLOSE_ACK), 64'd0);
    wait_drain("after_close");

    // ESTABLISHED drops mid-burst; next session restarts seq and rr.
    acc[1] = 0;
    push_hdr(1, 3); pkt(1, 4);
    wait_left(3);
    bus.USER_SESSION_ESTABLISHED = 1'b0;
    step();
    chk("est_ready", 64'(bus.CH_READY), 64'd0);
    chk("est_busy", 64'(bus.BUSY), 64'd0);
    step();
    step();
    chk("est_abandoned", 64'(sb.size()), 64'(4 - acc[1]));
    sb.delete();
    srcq[1].delete();
    step();
    bus.USER_SESSION_ESTABLISHED = 1'b1;
    push_hdr(0, 0); pkt(0, 1);
    push_hdr(2, 0); pkt(2, 1);
    wait_drain("new_session");

    // Asynchronous reset mid-burst.
    push_hdr(3, 0); pkt(3, 4);
    wait_left(3);
    rst = 1'b1;
    #1;
    chk("arst_tx_d", bus.USER_TX_D, 64'd0);
    chk("arst_tx_b", 64'(bus.USER_TX_B), 64'd0);
    chk("arst_ready", 64'(bus.CH_READY), 64'd0);
    chk("arst_busy", 64'(bus.BUSY), 64'd0);
    chk("arst_grant", 64'(bus.GRANT_CH), 64'd0);
    chk("arst_ack", 64'(bus.USER_SESSION_CLOSE_ACK), 64'd0);
    sb.delete();
    srcq[3].delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_tx_b", 64'(bus.USER_TX_B), 64'd0);
      chk("post_rst_busy", 64'(bus.BUSY), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
